arcade_input_mapper: RTL and testbench

- Sits between hps_io and the game core (Pickin) in the Squash top level.
- Decodes PS/2 key events from hps_io (ps2_key[10:0]) into held key states and merges them with joystick_0/joystick_1.
- Produces per-player control vectors, start and test levels, and one shaped coin pulse per coin request, with a lockout gap.
- Replaces the ad-hoc key registers and the combinational coin OR in the top level.

---
 rtl/arcade_input_mapper.sv | 168 ++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and two joystick pads into registered player controls,
// and shapes coin requests into fixed-width pulses followed by a lockout gap.
module arcade_input_mapper #(
  parameter logic [23:0] COIN_PULSE = 24'd1200000,
  parameter logic [23:0] COIN_GAP   = 24'd1200000,
  parameter bit          AUTO_COIN  = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [6:0]  p1_ctrl,
  output logic [6:0]  p2_ctrl,
  output logic        start1,
  output logic        start2,
  output logic        test,
  output logic        coin1,
  output logic        coin_busy
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_state_e;

  logic        armed_q, old_tog_q;
  logic [6:0]  p1_key_q, p1_key_d, p2_key_q, p2_key_d;
  logic [1:0]  st1_key_q, st1_key_d, st2_key_q, st2_key_d, coin_key_q, coin_key_d;
  logic        test_key_q, test_key_d;
  logic [6:0]  p1_ctrl_q, p2_ctrl_q;
  logic        start1_q, start2_q, test_q;
  logic        start1_d, start2_d, creq, creq_q, coin_rise;
  logic        key_event, pressed;
  logic [8:0]  code;
  coin_state_e state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        unused_joy_bits;

  assign unused_joy_bits = ^{joystick_0[15:10], joystick_1[15:10]};

  // armed_q suppresses decoding until the toggle tracker has been loaded once.
  assign key_event = armed_q & (old_tog_q != ps2_key[10]);
  assign pressed   = ps2_key[9];
  assign code      = ps2_key[8:0];

  always_comb begin
    p1_key_d   = p1_key_q;
    p2_key_d   = p2_key_q;
    st1_key_d  = st1_key_q;
    st2_key_d  = st2_key_q;
    coin_key_d = coin_key_q;
    test_key_d = test_key_q;
    if (key_event) begin
      case (code)
        9'h075, 9'h175: p1_key_d[3]   = pressed;
        9'h072, 9'h172: p1_key_d[2]   = pressed;
        9'h06B, 9'h16B: p1_key_d[1]   = pressed;
        9'h074, 9'h174: p1_key_d[0]   = pressed;
        9'h014:         p1_key_d[4]   = pressed;
        9'h011:         p1_key_d[5]   = pressed;
        9'h029:         p1_key_d[6]   = pressed;
        9'h005:         st1_key_d[0]  = pressed;
        9'h016:         st1_key_d[1]  = pressed;
        9'h006:         st2_key_d[0]  = pressed;
        9'h01E:         st2_key_d[1]  = pressed;
        9'h02E:         coin_key_d[0] = pressed;
        9'h036:         coin_key_d[1] = pressed;
        9'h02D:         p2_key_d[3]   = pressed;
        9'h02B:         p2_key_d[2]   = pressed;
        9'h023:         p2_key_d[1]   = pressed;
        9'h034:         p2_key_d[0]   = pressed;
        9'h01C:         p2_key_d[4]   = pressed;
        9'h01B:         p2_key_d[5]   = pressed;
        9'h015:         p2_key_d[6]   = pressed;
        9'h02C:         test_key_d    = pressed;
        default:        ;
      endcase
    end
  end

  assign start1_d  = (|st1_key_d) | joystick_0[7] | joystick_1[7];
  assign start2_d  = (|st2_key_d) | joystick_0[8] | joystick_1[8];
  assign creq      = (|coin_key_d) | joystick_0[9] | joystick_1[9] |
                     (AUTO_COIN & (start1_d | start2_d));
  assign coin_rise = creq & ~creq_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      old_tog_q  <= 1'b0;
      p1_key_q   <= '0;
      p2_key_q   <= '0;
      st1_key_q  <= '0;
      st2_key_q  <= '0;
      coin_key_q <= '0;
      test_key_q <= 1'b0;
      p1_ctrl_q  <= '0;
      p2_ctrl_q  <= '0;
      start1_q   <= 1'b0;
      start2_q   <= 1'b0;
      test_q     <= 1'b0;
      creq_q     <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      old_tog_q  <= ps2_key[10];
      p1_key_q   <= p1_key_d;
      p2_key_q   <= p2_key_d;
      st1_key_q  <= st1_key_d;
      st2_key_q  <= st2_key_d;
      coin_key_q <= coin_key_d;
      test_key_q <= test_key_d;
      p1_ctrl_q  <= p1_key_d | joystick_0[6:0];
      p2_ctrl_q  <= p2_key_d | joystick_1[6:0];
      start1_q   <= start1_d;
      start2_q   <= start2_d;
      test_q     <= test_key_d;
      creq_q     <= creq;
    end
  end

  // Rises seen outside StIdle are dropped, never queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (coin_rise) begin
          state_d = StPulse;
          cnt_d   = COIN_PULSE - 24'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 24'd0) begin
          if (COIN_GAP == 24'd0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = COIN_GAP - 24'd1;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StGap: begin
        if (cnt_q == 24'd0) state_d = StIdle;
        else                cnt_d   = cnt_q - 24'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p1_ctrl   = p1_ctrl_q;
  assign p2_ctrl   = p2_ctrl_q;
  assign start1    = start1_q;
  assign start2    = start2_q;
  assign test      = test_q;
  assign coin1     = (state_q == StPulse);
  assign coin_busy = (state_q != StIdle);

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized bench for arcade_input_mapper: three coin configurations share one stimulus
// and are compared against a held-key / pulse-window reference model every cycle.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;

  logic [6:0] p1_a, p2_a, p1_b, p2_b, p1_c, p2_c;
  logic       s1_a, s2_a, t_a, coin_a, busy_a;
  logic       s1_b, s2_b, t_b, coin_b, busy_b;
  logic       s1_c, s2_c, t_c, coin_c, busy_c;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(.COIN_PULSE(24'd4), .COIN_GAP(24'd3), .AUTO_COIN(1'b1)) u_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_ctrl(p1_a), .p2_ctrl(p2_a), .start1(s1_a), .start2(s2_a), .test(t_a),
    .coin1(coin_a), .coin_busy(busy_a)
  );
  arcade_input_mapper #(.COIN_PULSE(24'd4), .COIN_GAP(24'd3), .AUTO_COIN(1'b0)) u_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_ctrl(p1_b), .p2_ctrl(p2_b), .start1(s1_b), .start2(s2_b), .test(t_b),
    .coin1(coin_b), .coin_busy(busy_b)
  );
  arcade_input_mapper #(.COIN_PULSE(24'd1), .COIN_GAP(24'd0), .AUTO_COIN(1'b1)) u_c (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_ctrl(p1_c), .p2_ctrl(p2_c), .start1(s1_c), .start2(s2_c), .test(t_c),
    .coin1(coin_c), .coin_busy(busy_c)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one held flag per scancode, coin pulses as accepted-edge windows.
  int   pw[3] = '{4, 4, 1};
  int   gw[3] = '{3, 3, 0};
  bit   ac[3] = '{1'b1, 1'b0, 1'b1};
  bit   held [0:511];
  bit   armed_m, tog_m;
  int   cyc = 0;
  int   acc[3];
  int   next_ok[3];
  bit   prev_creq[3];
  logic [6:0] e_p1, e_p2;
  logic e_s1, e_s2, e_test;

  function automatic logic [8:0] norm(input logic [8:0] c);
    if (c[7:0] == 8'h75 || c[7:0] == 8'h72 || c[7:0] == 8'h6B || c[7:0] == 8'h74)
      return {1'b0, c[7:0]};
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    armed_m = 1'b0;
    tog_m   = 1'b0;
    e_p1 = '0; e_p2 = '0; e_s1 = 1'b0; e_s2 = 1'b0; e_test = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc[i] = -100; next_ok[i] = 0; prev_creq[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit creq;
    cyc++;
    if (!armed_m) begin
      armed_m = 1'b1;
      tog_m   = ps2_key[10];
    end else if (ps2_key[10] != tog_m) begin
      tog_m = ps2_key[10];
      held[norm(ps2_key[8:0])] = ps2_key[9];
    end
    e_p1 = {held[9'h029], held[9'h011], held[9'h014], held[9'h075],
            held[9'h072], held[9'h06B], held[9'h074]} | joystick_0[6:0];
    e_p2 = {held[9'h015], held[9'h01B], held[9'h01C], held[9'h02D],
            held[9'h02B], held[9'h023], held[9'h034]} | joystick_1[6:0];
    e_s1   = held[9'h005] | held[9'h016] | joystick_0[7] | joystick_1[7];
    e_s2   = held[9'h006] | held[9'h01E] | joystick_0[8] | joystick_1[8];
    e_test = held[9'h02C];
    for (int i = 0; i < 3; i++) begin
      creq = held[9'h02E] | held[9'h036] | joystick_0[9] | joystick_1[9] |
             (ac[i] & (e_s1 | e_s2));
      if (creq && !prev_creq[i] && cyc >= next_ok[i]) begin
        acc[i]     = cyc;
        next_ok[i] = cyc + pw[i] + gw[i] + 1;
      end
      prev_creq[i] = creq;
    end
  endtask

  task automatic check_all();
    logic [2:0] coin_w, busy_w;
    coin_w = {coin_c, coin_b, coin_a};
    busy_w = {busy_c, busy_b, busy_a};
    check("p1_ctrl", {25'd0, p1_a}, {25'd0, e_p1});
    check("p2_ctrl", {25'd0, p2_a}, {25'd0, e_p2});
    check("start1", {31'd0, s1_a}, {31'd0, e_s1});
    check("start2", {31'd0, s2_b}, {31'd0, e_s2});
    check("test", {31'd0, t_c}, {31'd0, e_test});
    for (int i = 0; i < 3; i++) begin
      check($sformatf("coin1_%0d", i), {31'd0, coin_w[i]},
            {31'd0, (cyc >= acc[i] && cyc <= acc[i] + pw[i] - 1)});
      check($sformatf("busy_%0d", i), {31'd0, busy_w[i]},
            {31'd0, (cyc >= acc[i] && cyc <= acc[i] + pw[i] + gw[i] - 1)});
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_step();
    #1;
    check_all();
  endtask

  // Called away from the clock edge so the async assert is observable on its own.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic ps2_event(input logic [8:0] c, input logic p);
    ps2_key = {~ps2_key[10], p, c};
  endtask

  logic [8:0] codes [24] = '{9'h075, 9'h172, 9'h06B, 9'h174, 9'h014, 9'h011, 9'h029,
                             9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02D,
                             9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h015, 9'h02C,
                             9'h0AA, 9'h17A, 9'h000};
  bit rise_pat [21] = '{1,0,0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0};

  initial begin
    int hi_a, hi_b, bz_a, rises;
    logic prev;
    model_reset();
    #2;
    apply_reset();
    step();

    // Arrow key press / release / repeat without toggle
    ps2_event(9'h075, 1'b1);
    step();
    check("up_press", {31'd0, p1_a[3]}, 32'd1);
    ps2_event(9'h075, 1'b0);
    step();
    check("up_release", {31'd0, p1_a[3]}, 32'd0);
    ps2_key[9] = 1'b1;
    step();
    check("no_toggle", {31'd0, p1_a[3]}, 32'd0);

    // Held coin request yields exactly one pulse
    joystick_0[9] = 1'b1;
    hi_a = 0; bz_a = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi_a += int'(coin_a);
      bz_a += int'(busy_a);
    end
    check("coin_width", hi_a, 4);
    check("busy_width", bz_a, 7);
    joystick_0[9] = 1'b0;
    repeat (3) step();

    // Rise during gap is dropped; rise once idle gives a second pulse
    rises = 0; hi_a = 0; prev = coin_a;
    for (int i = 0; i < 21; i++) begin
      joystick_0[9] = rise_pat[i];
      step();
      if (coin_a && !prev) rises++;
      prev = coin_a;
      hi_a += int'(coin_a);
    end
    check("gap_rises", rises, 2);
    check("gap_high", hi_a, 8);

    // Start key with and without auto coin
    ps2_event(9'h016, 1'b1);
    hi_a = 0; hi_b = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      hi_a += int'(coin_a);
      hi_b += int'(coin_b);
    end
    check("start1_key", {31'd0, s1_b}, 32'd1);
    check("auto_coin", hi_a, 4);
    check("no_auto_coin", hi_b, 0);
    ps2_event(9'h016, 1'b0);
    repeat (8) step();

    // Key and pad on the same function in the same cycle
    ps2_event(9'h01C, 1'b1);
    joystick_1[4] = 1'b1;
    step();
    check("fire2_both", {31'd0, p2_a[4]}, 32'd1);
    ps2_event(9'h01C, 1'b0);
    step();
    check("fire2_pad", {31'd0, p2_a[4]}, 32'd1);
    joystick_1[4] = 1'b0;
    step();
    check("fire2_none", {31'd0, p2_a[4]}, 32'd0);
    ps2_event(9'h0AA, 1'b1);
    step();

    // Reset mid-pulse, with a stale toggle left on ps2_key
    joystick_0[9] = 1'b1;
    repeat (2) step();
    #2;
    apply_reset();
    check("reset_coin", {31'd0, coin_a}, 32'd0);
    joystick_0[9] = 1'b0;
    ps2_event(9'h075, 1'b1);
    #2;
    step();
    check("stale_toggle", {31'd0, p1_a[3]}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 4) ps2_event(codes[$urandom_range(0, 23)], 1'($urandom_range(0, 1)));
      else if (r < 6) ps2_key[9:0] = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 23)]};
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) joystick_0[$urandom_range(0, 9)] ^= 1'b1;
        else                           joystick_1[$urandom_range(0, 9)] ^= 1'b1;
      end
      if ($urandom_range(0, 31) == 0) begin
        joystick_0[15:10] = 6'($urandom);
        joystick_1[15:10] = 6'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1);
  end

endmodule
